chdr_flush_sequencer: RTL and testbench

//  Sequences flush of NUM_PORTS axis_data_to_chdr instances sharing one flush_en/flush_timeout.

---
 rtl/chdr_flush_pkg.sv | 15 +
 rtl/chdr_flush_sequencer_if.sv | 24 ++
 rtl/flush_wdog.sv | 27 ++
 rtl/chdr_flush_sequencer.sv | 114 +++++++++++
 tb/tb_chdr_flush_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/chdr_flush_pkg.sv
// Shared types and default widths for the CHDR flush sequencer slice.
package chdr_flush_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_DONE,
        RELEASE
    } flush_state_t;

    localparam int NUM_PORTS_DEF = 2;
    localparam int TMO_W_DEF     = 32;
    localparam int WDOG_W_DEF    = 20;

endpackage

// File: rtl/chdr_flush_sequencer_if.sv
// Sequencer <-> converter flush bus; master is the sequencer, slave the converters.
interface chdr_flush_sequencer_if #(
    parameter int NUM_PORTS = 2,
    parameter int TMO_W     = 32
);
    logic                 flush_en_o;
    logic [TMO_W-1:0]     flush_timeout_o;
    logic [NUM_PORTS-1:0] flush_active_i;
    logic [NUM_PORTS-1:0] flush_done_i;

    modport master (
        output flush_en_o,
        output flush_timeout_o,
        input  flush_active_i,
        input  flush_done_i
    );

    modport slave (
        input  flush_en_o,
        input  flush_timeout_o,
        output flush_active_i,
        output flush_done_i
    );
endinterface

// File: rtl/flush_wdog.sv
// Saturating watchdog counter; expired flags the last allowed cycle (limit 0 acts as 1).
module flush_wdog #(
    parameter int WDOG_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr,
    input  logic              en,
    input  logic [WDOG_W-1:0] limit,
    output logic              expired
);
    localparam logic [WDOG_W-1:0] ONE = WDOG_W'(1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] lim_eff;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign lim_eff = (limit == '0) ? ONE : limit;
    assign expired = en && (cnt_q == (lim_eff - ONE));
endmodule

// File: rtl/chdr_flush_sequencer.sv
// Sequences a shared flush of the data-to-CHDR converters: arm, collect done, release.
module chdr_flush_sequencer
    import chdr_flush_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int TMO_W     = TMO_W_DEF,
    parameter int WDOG_W    = WDOG_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_req_i,
    input  logic                   abort_i,
    input  logic [NUM_PORTS-1:0]   chan_mask_i,
    input  logic [TMO_W-1:0]       flush_timeout_i,
    input  logic [WDOG_W-1:0]      wdog_limit_i,
    chdr_flush_sequencer_if.master conv,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NUM_PORTS-1:0]   done_mask_o,
    output logic                   err_o,
    output logic                   req_drop_o,
    output logic [7:0]             flush_cnt_o
);
    flush_state_t         state_q, state_nxt;
    logic [NUM_PORTS-1:0] mask_q;
    logic [NUM_PORTS-1:0] done_mask_q, done_mask_nxt;
    logic [TMO_W-1:0]     timeout_q;
    logic [WDOG_W-1:0]    limit_q;
    logic                 flush_en_q, busy_q, done_q, err_q, drop_q;
    logic [7:0]           cnt_q;
    logic                 all_done, chans_idle, wdog_exp;

    flush_wdog #(.WDOG_W(WDOG_W)) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (state_q != state_nxt),
        .en      ((state_q == WAIT_DONE) || (state_q == RELEASE)),
        .limit   (limit_q),
        .expired (wdog_exp)
    );

    assign done_mask_nxt = done_mask_q | (conv.flush_done_i & mask_q);
    assign all_done      = (done_mask_nxt & mask_q) == mask_q;
    assign chans_idle    = (conv.flush_active_i & mask_q) == '0;

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:      if (flush_req_i) state_nxt = ARM;
            ARM:       state_nxt = (mask_q == '0) ? RELEASE : WAIT_DONE;
            WAIT_DONE: if (all_done || wdog_exp || abort_i) state_nxt = RELEASE;
            RELEASE:   if (chans_idle || wdog_exp) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            timeout_q   <= '0;
            limit_q     <= '0;
            done_mask_q <= '0;
            flush_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_nxt;
            busy_q  <= (state_nxt != IDLE);
            done_q  <= 1'b0;
            drop_q  <= flush_req_i && (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (flush_req_i) begin
                        mask_q      <= chan_mask_i;
                        timeout_q   <= flush_timeout_i;
                        limit_q     <= wdog_limit_i;
                        done_mask_q <= '0;
                        err_q       <= 1'b0;
                    end
                end
                ARM: begin
                    if (mask_q != '0) flush_en_q <= 1'b1;
                end
                WAIT_DONE: begin
                    done_mask_q <= done_mask_nxt;
                    // A flush that completes on the expiry cycle still counts as clean.
                    if (!all_done && (wdog_exp || abort_i)) err_q <= 1'b1;
                    if (state_nxt == RELEASE) flush_en_q <= 1'b0;
                end
                RELEASE: begin
                    if (state_nxt == IDLE) begin
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + 8'd1;
                        if (!chans_idle) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign conv.flush_en_o      = flush_en_q;
    assign conv.flush_timeout_o = timeout_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign done_mask_o          = done_mask_q;
    assign err_o                = err_q;
    assign req_drop_o           = drop_q;
    assign flush_cnt_o          = cnt_q;
endmodule

// File: tb/tb_chdr_flush_sequencer.sv
// Directed bench for chdr_flush_sequencer with hand-computed cycle expectations.
module tb_chdr_flush_sequencer;
    localparam int NP = 2;
    localparam int TW = 32;
    localparam int WW = 20;

    logic          clk = 1'b0;
    logic          rst, req, abort;
    logic [NP-1:0] mask;
    logic [TW-1:0] tmo;
    logic [WW-1:0] lim;
    logic          busy, done, err, drop;
    logic [NP-1:0] dmask;
    logic [7:0]    cnt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int drop_seen = 0;
    int en_seen = 0;

    chdr_flush_sequencer_if #(.NUM_PORTS(NP), .TMO_W(TW)) conv ();

    chdr_flush_sequencer #(.NUM_PORTS(NP), .TMO_W(TW), .WDOG_W(WW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_req_i     (req),
        .abort_i         (abort),
        .chan_mask_i     (mask),
        .flush_timeout_i (tmo),
        .wdog_limit_i    (lim),
        .conv            (conv),
        .busy_o          (busy),
        .done_o          (done),
        .done_mask_o     (dmask),
        .err_o           (err),
        .req_drop_o      (drop),
        .flush_cnt_o     (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        done_seen += int'(done);
        drop_seen += int'(drop);
        en_seen   += int'(conv.flush_en_o);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; abort = 1'b0; mask = '0; tmo = '0; lim = '0;
        conv.flush_active_i = '0;
        conv.flush_done_i   = '0;
        ticks(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(conv.flush_en_o), 32'd0);
        check("rst_tmo", conv.flush_timeout_o, 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        tick();

        // 1: two channels, staggered done, active drops two cycles after flush_en falls
        req = 1'b1; mask = 2'b11; tmo = 32'hABCD1234; lim = 20'd100;
        tick();
        req = 1'b0; mask = 2'b00; tmo = 32'h0;
        check("t1_arm_busy", 32'(busy), 32'd1);
        check("t1_arm_en", 32'(conv.flush_en_o), 32'd0);
        tick();
        check("t1_en_up", 32'(conv.flush_en_o), 32'd1);
        check("t1_tmo_latched", conv.flush_timeout_o, 32'hABCD1234);
        conv.flush_active_i = 2'b11;
        ticks(4);
        conv.flush_done_i = 2'b01;
        ticks(4);
        check("t1_wait_en", 32'(conv.flush_en_o), 32'd1);
        check("t1_partial_mask", 32'(dmask), 32'd1);
        conv.flush_done_i = 2'b11;
        tick();
        check("t1_en_down", 32'(conv.flush_en_o), 32'd0);
        check("t1_dmask", 32'(dmask), 32'd3);
        conv.flush_done_i = 2'b00;
        ticks(2);
        check("t1_release_hold", 32'(done), 32'd0);
        conv.flush_active_i = 2'b00;
        req = 1'b1;
        tick();
        req = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_drop_at_done", 32'(drop), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_cnt", 32'(cnt), 32'd1);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: watchdog expiry with ch0 never done; ch1 done is outside the mask
        req = 1'b1; mask = 2'b01; lim = 20'd16;
        tick();
        req = 1'b0;
        tick();
        conv.flush_active_i = 2'b01;
        conv.flush_done_i   = 2'b10;
        ticks(15);
        check("t2_en_hold", 32'(conv.flush_en_o), 32'd1);
        check("t2_err_pre", 32'(err), 32'd0);
        tick();
        check("t2_en_fall", 32'(conv.flush_en_o), 32'd0);
        check("t2_err", 32'(err), 32'd1);
        check("t2_dmask", 32'(dmask), 32'd0);
        conv.flush_active_i = 2'b00;
        conv.flush_done_i   = 2'b00;
        tick();
        check("t2_done", 32'(done), 32'd1);
        check("t2_cnt", 32'(cnt), 32'd2);
        tick();

        // 3: empty mask skips the converters entirely
        en_seen = 0;
        conv.flush_active_i = 2'b11;
        req = 1'b1; mask = 2'b00;
        tick();
        req = 1'b0;
        tick();
        check("t3_no_done_early", 32'(done), 32'd0);
        tick();
        check("t3_done", 32'(done), 32'd1);
        check("t3_err_cleared", 32'(err), 32'd0);
        check("t3_cnt", 32'(cnt), 32'd3);
        check("t3_en_never", 32'(en_seen), 32'd0);
        conv.flush_active_i = 2'b00;
        tick();

        // 4: abort during WAIT_DONE, extra request during RELEASE
        done_seen = 0; drop_seen = 0;
        req = 1'b1; mask = 2'b11; lim = 20'd100;
        tick();
        req = 1'b0;
        tick();
        conv.flush_active_i = 2'b11;
        conv.flush_done_i   = 2'b01;
        ticks(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_err", 32'(err), 32'd1);
        check("t4_en_fall", 32'(conv.flush_en_o), 32'd0);
        check("t4_dmask", 32'(dmask), 32'd1);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("t4_drop", 32'(drop), 32'd1);
        tick();
        conv.flush_active_i = 2'b00;
        conv.flush_done_i   = 2'b00;
        ticks(4);
        check("t4_done_once", 32'(done_seen), 32'd1);
        check("t4_drop_once", 32'(drop_seen), 32'd1);
        check("t4_cnt", 32'(cnt), 32'd4);
        check("t4_idle", 32'(busy), 32'd0);

        // 5: reset mid-flush, then a clean minimum-latency flush
        done_seen = 0;
        req = 1'b1; mask = 2'b11; tmo = 32'h55; lim = 20'd100;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_en", 32'(conv.flush_en_o), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_tmo", conv.flush_timeout_o, 32'd0);
        check("t5_cnt", 32'(cnt), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        ticks(3);
        check("t5_no_done", 32'(done_seen), 32'd0);
        req = 1'b1; mask = 2'b01; conv.flush_done_i = 2'b01;
        tick();
        req = 1'b0;
        check("t5_lat_arm", 32'(conv.flush_en_o), 32'd0);
        tick();
        check("t5_lat_en", 32'(conv.flush_en_o), 32'd1);
        tick();
        check("t5_lat_rel", 32'(done), 32'd0);
        tick();
        check("t5_lat_done", 32'(done), 32'd1);
        check("t5_cnt_after", 32'(cnt), 32'd1);
        check("t5_err_after", 32'(err), 32'd0);

        // 6: counter wrap over 256 back-to-back flushes, ch1 done ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_seen = 0; drop_seen = 0;
        conv.flush_done_i = 2'b11;
        for (int n = 0; n < 256; n++) begin
            req = 1'b1; mask = 2'b01;
            tick();
            req = 1'b0;
            ticks(3);
            if (n == 254) check("t6_cnt_255", 32'(cnt), 32'd255);
        end
        check("t6_cnt_wrap", 32'(cnt), 32'd0);
        check("t6_dmask", 32'(dmask), 32'd1);
        check("t6_done_count", 32'(done_seen), 32'd256);
        check("t6_no_drop", 32'(drop_seen), 32'd0);
        conv.flush_done_i = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
